// File: rtl/sram_sequencer.sv
// Shares one asynchronous 512Kx8 SRAM between video (fixed priority) and CPU/DMA (round-robin),
// generating registered address, strobe, drive and read-latch timing for every access.
module sram_sequencer #(
    parameter int AW      = 19,
    parameter int RD_WAIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_wdata,
    output logic [7:0]    dma_rdata,
    output logic          dma_ack,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_wdata,
    output logic          sram_drive,
    input  logic [7:0]    sram_rdata,
    output logic          sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_ADDR   = 3'd1,
        S_RD_WAIT   = 3'd2,
        S_RD_LATCH  = 3'd3,
        S_WR_SETUP  = 3'd4,
        S_WR_STROBE = 3'd5,
        S_WR_HOLD   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_t;

    localparam logic [1:0] RD_WAIT_LAST = 2'(RD_WAIT - 1);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic          prefer_dma_q, prefer_dma_d;
    logic [1:0]    wait_cnt_q, wait_cnt_d;
    logic [AW-1:0] sram_addr_q, sram_addr_d;
    logic [7:0]    sram_wdata_q, sram_wdata_d;
    logic          sram_drive_q, sram_drive_d;
    logic          sram_we_n_q, sram_we_n_d;
    logic [7:0]    vid_data_q, vid_data_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic          vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
    logic          decide_s, vid_elig_s, cpu_elig_s, dma_elig_s;

    // A requester is invisible while its own access is in flight and during its ack cycle.
    assign vid_elig_s = vid_req && !vid_ack_q && (owner_q != OWN_VID);
    assign cpu_elig_s = cpu_req && !cpu_ack_q && (owner_q != OWN_CPU);
    assign dma_elig_s = dma_req && !dma_ack_q && (owner_q != OWN_DMA);

    // Next-state, arbitration and next-output logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        prefer_dma_d = prefer_dma_q;
        wait_cnt_d   = wait_cnt_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_drive_d = sram_drive_q;
        sram_we_n_d  = 1'b1;
        vid_data_d   = vid_data_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        vid_ack_d    = 1'b0;
        cpu_ack_d    = 1'b0;
        dma_ack_d    = 1'b0;
        decide_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                decide_s = 1'b1;
            end
            S_RD_ADDR: begin
                if (RD_WAIT == 0) begin
                    state_d = S_RD_LATCH;
                end else begin
                    state_d    = S_RD_WAIT;
                    wait_cnt_d = 2'd0;
                end
            end
            S_RD_WAIT: begin
                if (wait_cnt_q == RD_WAIT_LAST) begin
                    state_d = S_RD_LATCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_RD_LATCH: begin
                decide_s = 1'b1;
                case (owner_q)
                    OWN_VID: begin vid_data_d  = sram_rdata; vid_ack_d = 1'b1; end
                    OWN_CPU: begin cpu_rdata_d = sram_rdata; cpu_ack_d = 1'b1; end
                    OWN_DMA: begin dma_rdata_d = sram_rdata; dma_ack_d = 1'b1; end
                    default: ;
                endcase
            end
            S_WR_SETUP: begin
                state_d     = S_WR_STROBE;
                sram_we_n_d = 1'b0;
            end
            S_WR_STROBE: begin
                state_d = S_WR_HOLD;
            end
            S_WR_HOLD: begin
                decide_s = 1'b1;
                case (owner_q)
                    OWN_CPU: cpu_ack_d = 1'b1;
                    OWN_DMA: dma_ack_d = 1'b1;
                    default: ;
                endcase
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        // The driver stays on only when a write follows a write directly.
        if (decide_s) begin
            state_d      = S_IDLE;
            owner_d      = OWN_NONE;
            sram_drive_d = 1'b0;
            if (vid_elig_s) begin
                owner_d     = OWN_VID;
                state_d     = S_RD_ADDR;
                sram_addr_d = vid_addr;
            end else if (cpu_elig_s && (!dma_elig_s || !prefer_dma_q)) begin
                owner_d      = OWN_CPU;
                prefer_dma_d = 1'b1;
                sram_addr_d  = cpu_addr;
                if (cpu_we) begin
                    state_d      = S_WR_SETUP;
                    sram_wdata_d = cpu_wdata;
                    sram_drive_d = 1'b1;
                end else begin
                    state_d = S_RD_ADDR;
                end
            end else if (dma_elig_s) begin
                owner_d      = OWN_DMA;
                prefer_dma_d = 1'b0;
                sram_addr_d  = dma_addr;
                if (dma_we) begin
                    state_d      = S_WR_SETUP;
                    sram_wdata_d = dma_wdata;
                    sram_drive_d = 1'b1;
                end else begin
                    state_d = S_RD_ADDR;
                end
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            owner_d = owner_d;
        end
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_NONE;
            prefer_dma_q <= 1'b0;
            wait_cnt_q   <= 2'd0;
            sram_addr_q  <= {AW{1'b0}};
            sram_wdata_q <= 8'd0;
            sram_drive_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
            vid_data_q   <= 8'd0;
            cpu_rdata_q  <= 8'd0;
            dma_rdata_q  <= 8'd0;
            vid_ack_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            prefer_dma_q <= prefer_dma_d;
            wait_cnt_q   <= wait_cnt_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_drive_q <= sram_drive_d;
            sram_we_n_q  <= sram_we_n_d;
            vid_data_q   <= vid_data_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            vid_ack_q    <= vid_ack_d;
            cpu_ack_q    <= cpu_ack_d;
            dma_ack_q    <= dma_ack_d;
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_drive = sram_drive_q;
    assign sram_we_n  = sram_we_n_q;
    assign vid_data   = vid_data_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign vid_ack    = vid_ack_q;
    assign cpu_ack    = cpu_ack_q;
    assign dma_ack    = dma_ack_q;

endmodule

// File: tb/tb_sram_sequencer.sv
// Directed bench for sram_sequencer: a zero-wait instance on an SRAM model plus a
// two-wait-state instance whose read data is driven cycle by cycle.
module tb_sram_sequencer;
    localparam int AW = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] vid_addr = 19'd0, cpu_addr = 19'd0, dma_addr = 19'd0;
    logic [7:0]    cpu_wdata = 8'd0, dma_wdata = 8'd0;
    logic [7:0]    vid_data, cpu_rdata, dma_rdata, sram_wdata, sram_rdata;
    logic          vid_ack, cpu_ack, dma_ack, sram_drive, sram_we_n;
    logic [AW-1:0] sram_addr;

    logic          w_vid_req = 1'b0, w_cpu_req = 1'b0, w_cpu_we = 1'b0, w_dma_req = 1'b0, w_dma_we = 1'b0;
    logic [AW-1:0] w_vid_addr = 19'd0, w_cpu_addr = 19'd0, w_dma_addr = 19'd0;
    logic [7:0]    w_cpu_wdata = 8'd0, w_dma_wdata = 8'd0, w_sram_rdata = 8'd0;
    logic [7:0]    w_vid_data, w_cpu_rdata, w_dma_rdata, w_sram_wdata;
    logic          w_vid_ack, w_cpu_ack, w_dma_ack, w_sram_drive, w_sram_we_n;
    logic [AW-1:0] w_sram_addr;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = 19'd0;
    logic [7:0]    pre_data = 8'd0;

    int n_checks = 0, n_pass = 0, n_fail = 0, n_acks = 0, cyc = 0;
    logic prev_c = 1'b0, prev_d = 1'b0;

    assign sram_rdata = mem[sram_addr];
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (!sram_we_n && sram_drive) mem[sram_addr] <= sram_wdata;
    end

    sram_sequencer #(.AW(AW), .RD_WAIT(0)) u_dut (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_drive(sram_drive),
        .sram_rdata(sram_rdata), .sram_we_n(sram_we_n)
    );

    sram_sequencer #(.AW(AW), .RD_WAIT(2)) u_dut_w (
        .clk(clk), .rst(rst),
        .vid_req(w_vid_req), .vid_addr(w_vid_addr), .vid_data(w_vid_data), .vid_ack(w_vid_ack),
        .cpu_req(w_cpu_req), .cpu_we(w_cpu_we), .cpu_addr(w_cpu_addr), .cpu_wdata(w_cpu_wdata),
        .cpu_rdata(w_cpu_rdata), .cpu_ack(w_cpu_ack),
        .dma_req(w_dma_req), .dma_we(w_dma_we), .dma_addr(w_dma_addr), .dma_wdata(w_dma_wdata),
        .dma_rdata(w_dma_rdata), .dma_ack(w_dma_ack),
        .sram_addr(w_sram_addr), .sram_wdata(w_sram_wdata), .sram_drive(w_sram_drive),
        .sram_rdata(w_sram_rdata), .sram_we_n(w_sram_we_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    initial begin
        // Reset state and SRAM model contents.
        tick();
        preload(19'h12345, 8'hA5);
        preload(19'h00100, 8'h5A);
        preload(19'h00200, 8'hC3);
        preload(19'h00400, 8'h69);
        preload(19'h00055, 8'hEE);
        check("rst_we_n", sram_we_n, 1);
        check("rst_drive", sram_drive, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_wdata", sram_wdata, 0);
        check("rst_acks", {vid_ack, cpu_ack, dma_ack}, 0);
        check("rst_rdata", {vid_data, cpu_rdata, dma_rdata}, 0);
        rst = 1'b0;

        // Reset asserted in the middle of a write strobe.
        tick();
        cpu_addr = 19'h00055; cpu_wdata = 8'h11; cpu_we = 1'b1; cpu_req = 1'b1;
        tick();
        check("mw_setup_drive", sram_drive, 1);
        tick();
        check("mw_strobe_we_n", sram_we_n, 0);
        rst = 1'b1; cpu_req = 1'b0;
        #1;
        check("mw_rst_we_n", sram_we_n, 1);
        check("mw_rst_drive", sram_drive, 0);
        tick();
        rst = 1'b0;
        tick();
        check("mw_idle_we_n", sram_we_n, 1);
        check("mw_idle_ack", cpu_ack, 0);
        check("mw_no_write", mem[19'h00055], 8'hEE);

        // Single CPU read.
        cpu_we = 1'b0; cpu_addr = 19'h12345; cpu_req = 1'b1;
        check("rd_n_drive", sram_drive, 0);
        tick();
        check("rd_n1_addr", sram_addr, 19'h12345);
        check("rd_n1_ack", cpu_ack, 0);
        check("rd_n1_drive", sram_drive, 0);
        tick();
        check("rd_n2_ack", cpu_ack, 0);
        check("rd_n2_drive", sram_drive, 0);
        tick();
        check("rd_n3_ack", cpu_ack, 1);
        check("rd_n3_data", cpu_rdata, 8'hA5);
        check("rd_n3_drive", sram_drive, 0);
        tick();
        cpu_req = 1'b0;
        check("rd_n4_ack", cpu_ack, 0);
        tick();
        check("rd_n5_ack", cpu_ack, 0);
        check("rd_hold_data", cpu_rdata, 8'hA5);

        // Single DMA write at the top address.
        dma_we = 1'b1; dma_addr = 19'h7FFFF; dma_wdata = 8'h3C; dma_req = 1'b1;
        check("wr_n_addr_hold", sram_addr, 19'h12345);
        tick();
        check("wr_n1_addr", sram_addr, 19'h7FFFF);
        check("wr_n1_data", sram_wdata, 8'h3C);
        check("wr_n1_drive", sram_drive, 1);
        check("wr_n1_we_n", sram_we_n, 1);
        tick();
        check("wr_n2_we_n", sram_we_n, 0);
        check("wr_n2_addr", sram_addr, 19'h7FFFF);
        check("wr_n2_data", sram_wdata, 8'h3C);
        tick();
        check("wr_n3_we_n", sram_we_n, 1);
        check("wr_n3_drive", sram_drive, 1);
        check("wr_n3_addr", sram_addr, 19'h7FFFF);
        check("wr_n3_data", sram_wdata, 8'h3C);
        check("wr_n3_ack", dma_ack, 0);
        tick();
        check("wr_n4_ack", dma_ack, 1);
        check("wr_n4_drive", sram_drive, 0);
        tick();
        dma_req = 1'b0;
        check("wr_n5_ack", dma_ack, 0);
        check("wr_mem", mem[19'h7FFFF], 8'h3C);

        // CPU and DMA both requesting continuously: grants alternate starting with CPU.
        tick();
        dma_we = 1'b0; dma_addr = 19'h00200; cpu_addr = 19'h00100;
        cpu_req = 1'b1; dma_req = 1'b1;
        while (n_acks < 4 && cyc < 40) begin
            if (cpu_ack || dma_ack) begin
                check("rr_single_ack", {31'd0, cpu_ack & dma_ack}, 0);
                check("rr_order", {31'd0, dma_ack}, {31'd0, n_acks[0]});
                check("rr_no_repeat", {31'd0, (cpu_ack & prev_c) | (dma_ack & prev_d)}, 0);
                if (cpu_ack) check("rr_cpu_data", cpu_rdata, 8'h5A);
                else check("rr_dma_data", dma_rdata, 8'hC3);
                n_acks++;
            end
            prev_c = cpu_ack;
            prev_d = dma_ack;
            tick();
            cpu_req = !prev_c;
            dma_req = !prev_d;
            cyc++;
        end
        check("rr_done", n_acks, 4);
        cpu_req = 1'b0; dma_req = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("rr_drained", {cpu_ack, dma_ack}, 0);

        // Video arrives during a CPU write while DMA is pending.
        cpu_we = 1'b1; cpu_addr = 19'h00300; cpu_wdata = 8'h77; cpu_req = 1'b1;
        tick();
        vid_addr = 19'h12345; vid_req = 1'b1;
        dma_we = 1'b0; dma_addr = 19'h00400; dma_req = 1'b1;
        check("vp_setup_we_n", sram_we_n, 1);
        tick();
        check("vp_strobe_we_n", sram_we_n, 0);
        tick();
        check("vp_hold_ack", cpu_ack, 0);
        tick();
        check("vp_cpu_ack", cpu_ack, 1);
        check("vp_vid_addr", sram_addr, 19'h12345);
        check("vp_vid_drive", sram_drive, 0);
        tick();
        cpu_req = 1'b0;
        check("vp_vid_ack_early", vid_ack, 0);
        tick();
        check("vp_vid_ack", vid_ack, 1);
        check("vp_vid_data", vid_data, 8'hA5);
        check("vp_dma_addr", sram_addr, 19'h00400);
        check("vp_dma_ack_early", dma_ack, 0);
        tick();
        vid_req = 1'b0;
        check("vp_dma_ack_n7", dma_ack, 0);
        tick();
        check("vp_dma_ack", dma_ack, 1);
        check("vp_dma_data", dma_rdata, 8'h69);
        tick();
        dma_req = 1'b0;
        check("vp_mem", mem[19'h00300], 8'h77);

        // Two wait states: data sampled at the end of n+4, ack at n+5.
        w_cpu_addr = 19'h01234; w_sram_rdata = 8'h11; w_cpu_req = 1'b1;
        tick();
        check("rw_n1_addr", w_sram_addr, 19'h01234);
        check("rw_n1_ack", w_cpu_ack, 0);
        tick();
        check("rw_n2_ack", w_cpu_ack, 0);
        tick();
        check("rw_n3_ack", w_cpu_ack, 0);
        tick();
        w_sram_rdata = 8'h99;
        check("rw_n4_ack", w_cpu_ack, 0);
        tick();
        w_sram_rdata = 8'h22;
        check("rw_n5_ack", w_cpu_ack, 1);
        check("rw_n5_data", w_cpu_rdata, 8'h99);
        tick();
        w_cpu_req = 1'b0;
        check("rw_n6_ack", w_cpu_ack, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
